// File: rtl/oled_pkg.sv
// ============================================================================
// Module   : oled_pkg
// Purpose  : SSD1306 opcodes, decoder state type and default geometry shared
//            by the OLED SPI receiver.
// Revision : 1.0
// ============================================================================
`default_nettype none

package oled_pkg;

    localparam int DEF_WIDTH = 128;
    localparam int DEF_PAGES = 8;

    localparam logic [7:0] OP_MEMMODE    = 8'h20;
    localparam logic [7:0] OP_COLADDR    = 8'h21;
    localparam logic [7:0] OP_PAGEADDR   = 8'h22;
    localparam logic [7:0] OP_DISP_OFF   = 8'hAE;
    localparam logic [7:0] OP_DISP_ON    = 8'hAF;
    localparam logic [7:0] OP_CONTRAST   = 8'h81;
    localparam logic [7:0] OP_CHARGEPUMP = 8'h8D;
    localparam logic [7:0] OP_MUXRATIO   = 8'hA8;
    localparam logic [7:0] OP_DISPOFFSET = 8'hD3;
    localparam logic [7:0] OP_CLKDIV     = 8'hD5;
    localparam logic [7:0] OP_PRECHARGE  = 8'hD9;
    localparam logic [7:0] OP_COMPINS    = 8'hDA;
    localparam logic [7:0] OP_VCOMDESEL  = 8'hDB;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_COL_START  = 3'd1,
        ST_COL_END    = 3'd2,
        ST_PAGE_START = 3'd3,
        ST_PAGE_END   = 3'd4,
        ST_SKIP1      = 3'd5
    } dec_state_t;

    // Commands whose single argument is consumed and discarded.
    function automatic logic is_one_arg(input logic [7:0] op);
        logic hit;
        hit = 1'b0;
        case (op)
            OP_MEMMODE, OP_CONTRAST, OP_CHARGEPUMP, OP_MUXRATIO, OP_DISPOFFSET,
            OP_CLKDIV, OP_PRECHARGE, OP_COMPINS, OP_VCOMDESEL: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/oled_spi_deser.sv
// ============================================================================
// Module   : oled_spi_deser
// Purpose  : MSB-first SPI byte deserializer with framing-error detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module oled_spi_deser (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pin_din,
    input  logic       pin_cs,
    input  logic       pin_dc,
    input  logic       pin_res,
    output logic       byte_valid,
    output logic       byte_is_data,
    output logic [7:0] rx_byte,
    output logic       err_frame
);

    logic [6:0] shreg;
    logic [2:0] bit_cnt;
    logic       dc_latch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg        <= '0;
            bit_cnt      <= '0;
            dc_latch     <= 1'b0;
            byte_valid   <= 1'b0;
            byte_is_data <= 1'b0;
            rx_byte      <= '0;
            err_frame    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            err_frame  <= 1'b0;
            if (!pin_res) begin
                bit_cnt <= '0;
            end else if (!pin_cs) begin
                shreg   <= {shreg[5:0], pin_din};
                bit_cnt <= bit_cnt + 3'd1;
                // D/C is taken with the last bit of the byte
                if (bit_cnt == 3'd7) begin
                    byte_valid   <= 1'b1;
                    rx_byte      <= {shreg, pin_din};
                    byte_is_data <= pin_dc;
                end
                if (bit_cnt == 3'd0) begin
                    dc_latch <= pin_dc;
                end
            end else if (bit_cnt != 3'd0) begin
                bit_cnt   <= '0;
                err_frame <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/oled_spi_rx.sv
// ============================================================================
// Module   : oled_spi_rx
// Purpose  : SSD1306-compatible SPI receiver: command decoder, windowed
//            write pointer and framebuffer with a host read port.
//            Optional OLED_SPI_RX_STATS_EN adds cmd_count/data_count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module oled_spi_rx
    import oled_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int PAGES  = DEF_PAGES,
    parameter int COL_W  = $clog2(WIDTH),
    parameter int PAGE_W = $clog2(PAGES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pin_din,
    input  logic              pin_cs,
    input  logic              pin_dc,
    input  logic              pin_res,
    output logic              byte_valid,
    output logic              byte_is_data,
    output logic [7:0]        rx_byte,
    output logic              display_on,
    output logic              frame_done,
    output logic              err_frame,
    input  logic [PAGE_W-1:0] rd_page,
    input  logic [COL_W-1:0]  rd_col,
    output logic [7:0]        rd_data
`ifdef OLED_SPI_RX_STATS_EN
    ,
    output logic [15:0]       cmd_count,
    output logic [15:0]       data_count
`endif
);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);
    localparam int                FB_DEPTH  = 2 ** (PAGE_W + COL_W);

    dec_state_t        state;
    logic [COL_W-1:0]  col_start, col_end, col, pend_col;
    logic [PAGE_W-1:0] page_start, page_end, page, pend_page;
    logic [7:0]        fb [FB_DEPTH];
    logic              wr_en;

    oled_spi_deser u_deser (
        .clk          (clk),
        .rst_n        (rst_n),
        .pin_din      (pin_din),
        .pin_cs       (pin_cs),
        .pin_dc       (pin_dc),
        .pin_res      (pin_res),
        .byte_valid   (byte_valid),
        .byte_is_data (byte_is_data),
        .rx_byte      (rx_byte),
        .err_frame    (err_frame)
    );

    assign wr_en = byte_valid && byte_is_data && pin_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            col_start  <= '0;
            col_end    <= COL_LAST;
            page_start <= '0;
            page_end   <= PAGE_LAST;
            col        <= '0;
            page       <= '0;
            pend_col   <= '0;
            pend_page  <= '0;
            display_on <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!pin_res) begin
                state      <= ST_IDLE;
                col_start  <= '0;
                col_end    <= COL_LAST;
                page_start <= '0;
                page_end   <= PAGE_LAST;
                col        <= '0;
                page       <= '0;
                display_on <= 1'b0;
            end else if (byte_valid && byte_is_data) begin
                // Data aborts any half-parsed command and is still written.
                state <= ST_IDLE;
                if (col == col_end) begin
                    col <= col_start;
                    if (page == page_end) begin
                        page       <= page_start;
                        frame_done <= 1'b1;
                    end else begin
                        page <= (page == PAGE_LAST) ? '0 : page + PAGE_W'(1);
                    end
                end else begin
                    col <= (col == COL_LAST) ? '0 : col + COL_W'(1);
                end
            end else if (byte_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_byte == OP_COLADDR)       state <= ST_COL_START;
                        else if (rx_byte == OP_PAGEADDR) state <= ST_PAGE_START;
                        else if (is_one_arg(rx_byte))    state <= ST_SKIP1;
                        else if (rx_byte == OP_DISP_ON)  display_on <= 1'b1;
                        else if (rx_byte == OP_DISP_OFF) display_on <= 1'b0;
                    end
                    ST_COL_START: begin
                        pend_col <= rx_byte[COL_W-1:0];
                        state    <= ST_COL_END;
                    end
                    ST_COL_END: begin
                        col_start <= pend_col;
                        col_end   <= rx_byte[COL_W-1:0];
                        col       <= pend_col;
                        state     <= ST_IDLE;
                    end
                    ST_PAGE_START: begin
                        pend_page <= rx_byte[PAGE_W-1:0];
                        state     <= ST_PAGE_END;
                    end
                    ST_PAGE_END: begin
                        page_start <= pend_page;
                        page_end   <= rx_byte[PAGE_W-1:0];
                        page       <= pend_page;
                        state      <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fb[{page, col}] <= rx_byte;
        end
    end

    // Read-first: a same-cycle write to this address returns the old byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= fb[{rd_page, rd_col}];
        end
    end

`ifdef OLED_SPI_RX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_count  <= '0;
            data_count <= '0;
        end else if (!pin_res) begin
            cmd_count  <= '0;
            data_count <= '0;
        end else if (byte_valid) begin
            if (byte_is_data) begin
                if (data_count != 16'hFFFF) data_count <= data_count + 16'd1;
            end else begin
                if (cmd_count != 16'hFFFF) cmd_count <= cmd_count + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_oled_spi_rx.sv
// ============================================================================
// Module   : tb_oled_spi_rx
// Purpose  : Scoreboard bench for oled_spi_rx with a behavioural display model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_oled_spi_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pin_din = 1'b0;
    logic       pin_cs = 1'b1;
    logic       pin_dc = 1'b0;
    logic       pin_res = 1'b1;
    logic [2:0] rd_page = '0;
    logic [6:0] rd_col = '0;
    logic       byte_valid, byte_is_data, display_on, frame_done, err_frame;
    logic [7:0] rx_byte, rd_data;

    oled_spi_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pin_din      (pin_din),
        .pin_cs       (pin_cs),
        .pin_dc       (pin_dc),
        .pin_res      (pin_res),
        .byte_valid   (byte_valid),
        .byte_is_data (byte_is_data),
        .rx_byte      (rx_byte),
        .display_on   (display_on),
        .frame_done   (frame_done),
        .err_frame    (err_frame),
        .rd_page      (rd_page),
        .rd_col       (rd_col),
        .rd_data      (rd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [8:0] exp_bytes[$];
    int         exp_frames[$];
    int         sent_bytes = 0;
    int         seen_bytes = 0;
    int         err_seen = 0;
    int         err_exp = 0;

    // Display model: framebuffer, window, pointer and pending command.
    logic [7:0] m_fb [1024];
    bit         m_wr [1024];
    int         m_cs, m_ce, m_ps, m_pe, m_col, m_page;
    bit         m_disp;
    logic [7:0] m_pend;
    logic [7:0] m_args[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset_decoder();
        m_pend = 8'h00;
        m_args.delete();
        m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
        m_col = 0; m_page = 0;
        m_disp = 1'b0;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input logic dc);
        int idx;
        sent_bytes++;
        exp_bytes.push_back({dc, b});
        if (dc) begin
            m_pend = 8'h00;
            m_args.delete();
            idx = m_page * 128 + m_col;
            m_fb[idx] = b;
            m_wr[idx] = 1'b1;
            if (m_col == m_ce) begin
                m_col = m_cs;
                if (m_page == m_pe) begin
                    m_page = m_ps;
                    exp_frames.push_back(sent_bytes);
                end else begin
                    m_page = (m_page + 1) % 8;
                end
            end else begin
                m_col = (m_col + 1) % 128;
            end
        end else if (m_pend == 8'h21 || m_pend == 8'h22) begin
            m_args.push_back(b);
            if (m_args.size() == 2) begin
                if (m_pend == 8'h21) begin
                    m_cs = m_args[0] % 128; m_ce = m_args[1] % 128; m_col = m_cs;
                end else begin
                    m_ps = m_args[0] % 8; m_pe = m_args[1] % 8; m_page = m_ps;
                end
                m_pend = 8'h00;
                m_args.delete();
            end
        end else if (m_pend != 8'h00) begin
            m_pend = 8'h00;
        end else if (b inside {8'h21, 8'h22, 8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
                               8'hD5, 8'hD9, 8'hDA, 8'hDB}) begin
            m_pend = b;
        end else if (b == 8'hAF) begin
            m_disp = 1'b1;
        end else if (b == 8'hAE) begin
            m_disp = 1'b0;
        end
    endfunction

    task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            pin_cs  = 1'b0;
            pin_din = b[7-i];
            pin_dc  = dc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pin_cs = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        model_byte(b, dc);
        send_bits(b, dc, 8);
        idle($urandom_range(0, 2));
    endtask

    task automatic check_fb();
        for (int i = 0; i < 1024; i++) begin
            if (m_wr[i]) begin
                @(negedge clk);
                rd_page = 3'(i / 128);
                rd_col  = 7'(i % 128);
                @(negedge clk);
                check($sformatf("fb[%0d][%0d]", i / 128, i % 128), rd_data, m_fb[i]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_valid) begin
                seen_bytes++;
                if (exp_bytes.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_byte actual=%0h required=none", {byte_is_data, rx_byte});
                end else begin
                    check("rx_byte", {byte_is_data, rx_byte}, exp_bytes.pop_front());
                end
            end
            if (frame_done) begin
                if (exp_frames.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_frame_done actual=byte%0d required=none", seen_bytes);
                end else begin
                    check("frame_done_pos", seen_bytes, exp_frames.pop_front());
                end
            end
            if (err_frame) err_seen++;
        end
    end

    localparam int N_INIT = 25;
    logic [7:0] init_seq [N_INIT] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00,
                                      8'h40, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8,
                                      8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB,
                                      8'h40, 8'hA4, 8'hA6, 8'hAF};
    logic [7:0] one_args [9] = '{8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB};

    initial begin
        for (int i = 0; i < 1024; i++) m_wr[i] = 1'b0;
        model_reset_decoder();

        repeat (3) @(negedge clk);
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_rx_byte", rx_byte, 8'h00);
        check("rst_display_on", display_on, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_err_frame", err_frame, 1'b0);
        check("rst_rd_data", rd_data, 8'h00);
        rst_n = 1'b1;
        idle(2);

        // Init sequence, full window, 1024 bytes of index data.
        for (int i = 0; i < N_INIT; i++) send_byte(init_seq[i], 1'b0);
        send_byte(8'h21, 1'b0); send_byte(8'd0, 1'b0); send_byte(8'd127, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'd0, 1'b0); send_byte(8'd7, 1'b0);
        for (int i = 0; i < 1024; i++) begin
            model_byte(8'(i), 1'b1);
            send_bits(8'(i), 1'b1, 8);
        end
        idle(4);
        check("init_display_on", display_on, m_disp);
        check("init_frames_left", exp_frames.size(), 0);
        check_fb();

        // Small window 10..11 x 3..4.
        send_byte(8'h21, 1'b0); send_byte(8'd10, 1'b0); send_byte(8'd11, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'd3, 1'b0); send_byte(8'd4, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'hA1 + 8'(i), 1'b1);
        idle(3);
        check("win_frames_left", exp_frames.size(), 0);
        check_fb();

        // Column wrap 126..1 on page 0.
        send_byte(8'h21, 1'b0); send_byte(8'd126, 1'b0); send_byte(8'd1, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'd0, 1'b0); send_byte(8'd0, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
        idle(3);
        check_fb();

        // Framing error then a clean 0xAE.
        send_bits(8'hFF, 1'b0, 5);
        err_exp++;
        idle(3);
        send_byte(8'hAE, 1'b0);
        idle(3);
        check("err_frame_count", err_seen, err_exp);
        check("err_display_on", display_on, m_disp);

        // Data aborts a pending COLUMNADDR; one-arg skip eats 0x21.
        send_byte(8'h21, 1'b0);
        send_byte(8'h55, 1'b1);
        send_byte(8'h81, 1'b0); send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'd2, 1'b0); send_byte(8'd2, 1'b0);
        send_byte(8'h66, 1'b1); send_byte(8'h77, 1'b1);
        idle(3);
        check_fb();

        // Randomised command/data traffic.
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 5))
                0: begin
                    send_byte(8'h21, 1'b0);
                    send_byte(8'($urandom_range(0, 127)), 1'b0);
                    send_byte(8'($urandom_range(0, 127)), 1'b0);
                    send_byte(8'h22, 1'b0);
                    send_byte(8'($urandom_range(0, 7)), 1'b0);
                    send_byte(8'($urandom_range(0, 7)), 1'b0);
                    repeat ($urandom_range(1, 40)) send_byte(8'($urandom), 1'b1);
                end
                1: send_byte($urandom_range(0, 1) ? 8'hAF : 8'hAE, 1'b0);
                2: begin
                    send_byte(one_args[$urandom_range(0, 8)], 1'b0);
                    send_byte(8'($urandom), 1'b0);
                end
                3: begin
                    send_byte($urandom_range(0, 1) ? 8'h21 : 8'h22, 1'b0);
                    if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 1'b0);
                    send_byte(8'($urandom), 1'b1);
                end
                4: repeat ($urandom_range(1, 20)) send_byte(8'($urandom), 1'b1);
                default: send_byte(8'($urandom), 1'b0);
            endcase
        end
        idle(4);
        check("rand_display_on", display_on, m_disp);
        check_fb();

        // pin_res after a half-finished window command.
        send_byte(8'hAF, 1'b0);
        send_byte(8'h21, 1'b0); send_byte(8'd5, 1'b0);
        idle(3);
        @(negedge clk); pin_res = 1'b0;
        @(negedge clk); pin_res = 1'b1;
        model_reset_decoder();
        idle(2);
        check("res_display_on", display_on, m_disp);
        send_byte(8'h3C, 1'b1); send_byte(8'hC3, 1'b1);
        idle(3);
        check_fb();

        // Asynchronous reset in the middle of a byte.
        send_byte(8'hAF, 1'b0);
        idle(3);
        check("pre_rst_display_on", display_on, m_disp);
        send_bits(8'hA0, 1'b0, 3);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_display_on", display_on, 1'b0);
        check("arst_rx_byte", rx_byte, 8'h00);
        check("arst_rd_data", rd_data, 8'h00);
        @(negedge clk);
        check("arst_byte_valid", byte_valid, 1'b0);
        check("arst_err_frame", err_frame, 1'b0);
        pin_cs = 1'b1;
        exp_bytes.delete();
        exp_frames.delete();
        seen_bytes = sent_bytes;
        model_reset_decoder();
        @(negedge clk); rst_n = 1'b1;
        idle(3);
        check("post_arst_err_count", err_seen, err_exp);
        send_byte(8'h21, 1'b0); send_byte(8'd7, 1'b0); send_byte(8'd7, 1'b0);
        send_byte(8'hE7, 1'b1);
        idle(4);
        check("post_arst_rx_byte", rx_byte, 8'hE7);

        check("bytes_left", exp_bytes.size(), 0);
        check("frames_left", exp_frames.size(), 0);
        check("err_frame_total", err_seen, err_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
